// File: rtl/pa_store_pkg.sv
// Shared types and defaults for the banked sample store.
package pa_store_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 64;
    localparam int unsigned DEF_BANK_COUNT = 16;
    localparam int unsigned DEF_BANK_DEPTH = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd2,
        ST_READY = 2'd3
    } store_state_e;

    // Bit offset of a lane inside a packed row.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/bank_ram.sv
// Single-clock bank RAM: one write port, one registered read-first read port.
// fwd returns the write data instead of the stored word (same-address bypass).
module bank_ram #(
    parameter  int unsigned DATA_WIDTH = 64,
    parameter  int unsigned DEPTH      = 4096,
    localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    input  logic                  fwd,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= fwd ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/banked_sample_store.sv
// Multi-bank sample store: row-streamed load engine, masked row writes, registered row reads.
// Build option STORE_RAW_BYPASS_EN forwards same-cycle write data to a same-address read.
module banked_sample_store
    import pa_store_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int unsigned BANK_COUNT = DEF_BANK_COUNT,
    parameter  int unsigned BANK_DEPTH = DEF_BANK_DEPTH,
    localparam int unsigned ADDR_W     = $clog2(BANK_DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load_start,
    input  logic                             load_valid,
    input  logic [DATA_WIDTH*BANK_COUNT-1:0] load_data,
    output logic                             load_ready,
    output logic                             load_done,
    input  logic                             rd_en,
    input  logic [ADDR_W-1:0]                rd_addr,
    output logic                             rd_valid,
    output logic [DATA_WIDTH*BANK_COUNT-1:0] rd_data,
    input  logic                             wr_en,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_WIDTH*BANK_COUNT-1:0] wr_data,
    input  logic [BANK_COUNT-1:0]            wr_mask,
    output logic                             busy,
    output logic                             err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned ROW_W = DATA_WIDTH * BANK_COUNT;

    store_state_e state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;

    logic              beat_c;
    logic              cnt_clr_c;
    logic              rd_go_c;
    logic              wr_go_c;
    logic              same_addr_c;
    logic [ADDR_W-1:0] waddr_c;
    logic [ROW_W-1:0]  wdata_c;

    // Next-state and per-cycle strobes.
    always_comb begin
        state_d   = state_q;
        beat_c    = 1'b0;
        cnt_clr_c = 1'b0;
        rd_go_c   = 1'b0;
        wr_go_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d   = ST_LOAD;
                    cnt_clr_c = 1'b1;
                end
            end
            ST_LOAD: begin
                beat_c = load_valid;
                if (load_valid && (cnt_q == CNT_W'(BANK_DEPTH - 1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_READY;
            end
            ST_READY: begin
                rd_go_c = rd_en;
                wr_go_c = wr_en;
                if (load_start) begin
                    state_d   = ST_LOAD;
                    cnt_clr_c = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register and state-decoded outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            load_ready <= 1'b0;
            load_done  <= 1'b0;
            busy       <= 1'b1;
            err        <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_ready <= (state_d == ST_LOAD);
            load_done  <= (state_d == ST_DONE);
            busy       <= (state_d != ST_READY);
            err        <= (rd_en || wr_en) && (state_q != ST_READY);
            rd_valid   <= rd_go_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr_c) begin
            cnt_q <= '0;
        end else if (beat_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Load engine owns the write port while loading; otherwise the user write port.
    assign waddr_c = (state_q == ST_LOAD) ? cnt_q[ADDR_W-1:0] : wr_addr;
    assign wdata_c = (state_q == ST_LOAD) ? load_data : wr_data;

`ifdef STORE_RAW_BYPASS_EN
    assign same_addr_c = rd_go_c && wr_go_c && (rd_addr == wr_addr);
`else
    assign same_addr_c = 1'b0;
`endif

    for (genvar i = 0; i < BANK_COUNT; i++) begin : g_bank
        logic lane_we_c;
        logic lane_fwd_c;

        assign lane_we_c  = beat_c || (wr_go_c && wr_mask[i]);
        assign lane_fwd_c = same_addr_c && wr_mask[i];

        bank_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (BANK_DEPTH)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (lane_we_c),
            .waddr (waddr_c),
            .wdata (wdata_c[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
            .re    (rd_go_c),
            .raddr (rd_addr),
            .fwd   (lane_fwd_c),
            .rdata (rd_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_banked_sample_store.sv
// Directed bench for banked_sample_store with 4 banks x 8 rows x 16 bits.
module tb_banked_sample_store;
    import pa_store_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned BC = 4;
    localparam int unsigned BD = 8;
    localparam int unsigned AW = 3;

    logic          clk;
    logic          rst_n;
    logic          load_start;
    logic          load_valid;
    logic [63:0]   load_data;
    logic          load_ready;
    logic          load_done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [63:0]   rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [63:0]   wr_data;
    logic [BC-1:0] wr_mask;
    logic          busy;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;

    banked_sample_store #(
        .DATA_WIDTH (DW),
        .BANK_COUNT (BC),
        .BANK_DEPTH (BD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_done  (load_done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_mask    (wr_mask),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Row r, lane i holds {seed, r, i}.
    function automatic logic [63:0] pat(input int r, input logic [7:0] seed);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) v[i*16 +: 16] = {seed, 4'(r), 4'(i)};
        return v;
    endfunction

    task automatic read_row(input int a, input logic [63:0] exp, input string tag);
        rd_en = 1'b1;
        rd_addr = AW'(a);
        step();
        rd_en = 1'b0;
        check({tag, "_vld"}, 64'(rd_valid), 64'(1));
        check(tag, rd_data, exp);
    endtask

    task automatic load_beats(input logic [7:0] seed, input bit toggle);
        for (int r = 0; r < 8; r++) begin
            if (toggle) begin
                load_valid = 1'b0;
                step();
                check("ready_gap", 64'(load_ready), 64'(1));
            end
            load_valid = 1'b1;
            load_data = pat(r, seed);
            step();
            load_valid = 1'b0;
            check("busy_load", 64'(busy), 64'(1));
            check("done_flag", 64'(load_done), 64'(r == 7));
        end
        step();
        check("done_clear", 64'(load_done), 64'(0));
        check("busy_ready", 64'(busy), 64'(0));
    endtask

    task automatic load_all(input logic [7:0] seed, input bit toggle);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("ld_ready", 64'(load_ready), 64'(1));
        load_beats(seed, toggle);
    endtask

    initial begin
        logic [63:0] exp5;
        logic [63:0] new5;
        rst_n = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data = '0;
        rd_en = 1'b0;
        rd_addr = '0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_mask = '0;
        #12;
        check("rst_ready", 64'(load_ready), 64'(0));
        check("rst_done", 64'(load_done), 64'(0));
        check("rst_rvld", 64'(rd_valid), 64'(0));
        check("rst_rdata", rd_data, 64'(0));
        check("rst_busy", 64'(busy), 64'(1));
        check("rst_err", 64'(err), 64'(0));
        rst_n = 1'b1;
        step();

        // Read in IDLE is rejected with err
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("idle_err", 64'(err), 64'(1));
        check("idle_rvld", 64'(rd_valid), 64'(0));
        check("idle_rdata", rd_data, 64'(0));
        check("idle_ready", 64'(load_ready), 64'(0));
        step();
        check("idle_err_clr", 64'(err), 64'(0));

        // First load, with an ignored load_start and a rejected read mid-load
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("ld0_ready", 64'(load_ready), 64'(1));
        for (int r = 0; r < 8; r++) begin
            if (r == 4) begin
                load_valid = 1'b0;
                rd_en = 1'b1;
                rd_addr = 3'd1;
                step();
                rd_en = 1'b0;
                check("load_err", 64'(err), 64'(1));
                check("load_rvld", 64'(rd_valid), 64'(0));
                check("ready_moore", 64'(load_ready), 64'(1));
            end
            load_start = (r == 2);
            load_valid = 1'b1;
            load_data = pat(r, 8'h00);
            step();
            load_valid = 1'b0;
            load_start = 1'b0;
            check("ld0_done", 64'(load_done), 64'(r == 7));
            check("ld0_busy", 64'(busy), 64'(1));
        end
        check("done_ready", 64'(load_ready), 64'(0));
        // Access during DONE is rejected and must not touch memory
        wr_en = 1'b1;
        wr_addr = 3'd0;
        wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        wr_mask = 4'hF;
        rd_en = 1'b1;
        rd_addr = 3'd0;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("ld0_done_clr", 64'(load_done), 64'(0));
        check("ld0_busy_fall", 64'(busy), 64'(0));
        check("done_err", 64'(err), 64'(1));
        check("done_rvld", 64'(rd_valid), 64'(0));
        step();
        check("err_clr", 64'(err), 64'(0));

        for (int r = 0; r < 8; r++) read_row(r, pat(r, 8'h00), "rd_l0");
        step();
        check("hold_rvld", 64'(rd_valid), 64'(0));
        check("hold_rdata", rd_data, pat(7, 8'h00));

        // Masked write to row 3
        wr_en = 1'b1;
        wr_addr = 3'd3;
        wr_data = 64'hAAAA_AAAA_AAAA_AAAA;
        wr_mask = 4'b0101;
        step();
        wr_en = 1'b0;
        read_row(3, 64'h0033_AAAA_0031_AAAA, "rd_mask");

        // Empty mask is a no-op
        wr_en = 1'b1;
        wr_addr = 3'd7;
        wr_mask = 4'b0000;
        step();
        wr_en = 1'b0;
        read_row(7, pat(7, 8'h00), "rd_nomask");

        // Read and write to different rows in the same cycle
        wr_en = 1'b1;
        wr_addr = 3'd6;
        wr_data = 64'h6666_6666_6666_6666;
        wr_mask = 4'hF;
        rd_en = 1'b1;
        rd_addr = 3'd2;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("rw_diff_vld", 64'(rd_valid), 64'(1));
        check("rw_diff_rd", rd_data, pat(2, 8'h00));
        read_row(6, 64'h6666_6666_6666_6666, "rd_row6");

        // Read and write to the same row in the same cycle
        new5 = 64'h5A53_5A52_5A51_5A50;
`ifdef STORE_RAW_BYPASS_EN
        exp5 = new5;
`else
        exp5 = pat(5, 8'h00);
`endif
        wr_en = 1'b1;
        wr_addr = 3'd5;
        wr_data = new5;
        wr_mask = 4'hF;
        rd_en = 1'b1;
        rd_addr = 3'd5;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("raw_rd", rd_data, exp5);
        read_row(5, new5, "raw_follow");

        // Aborted load: reset after 5 accepted beats
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int r = 0; r < 5; r++) begin
            load_valid = 1'b1;
            load_data = pat(r, 8'hB0);
            step();
            load_valid = 1'b0;
            step();
        end
        rst_n = 1'b0;
        #1;
        check("abort_ready", 64'(load_ready), 64'(0));
        check("abort_done", 64'(load_done), 64'(0));
        check("abort_rvld", 64'(rd_valid), 64'(0));
        check("abort_rdata", rd_data, 64'(0));
        check("abort_busy", 64'(busy), 64'(1));
        check("abort_err", 64'(err), 64'(0));
        check("abort_state", 64'(dut.state_q), 64'(ST_IDLE));
        step();
        rst_n = 1'b1;
        step();
        check("abort_idle", 64'(load_ready), 64'(0));
        load_all(8'h01, 1'b1);
        for (int r = 0; r < 8; r++) read_row(r, pat(r, 8'h01), "rd_l1");

        // Reload from READY; the read issued with load_start is still serviced
        load_start = 1'b1;
        rd_en = 1'b1;
        rd_addr = 3'd0;
        step();
        load_start = 1'b0;
        rd_en = 1'b0;
        check("reld_rvld", 64'(rd_valid), 64'(1));
        check("reld_rd", rd_data, pat(0, 8'h01));
        check("reld_busy", 64'(busy), 64'(1));
        check("reld_ready", 64'(load_ready), 64'(1));
        load_beats(8'h02, 1'b0);
        for (int r = 0; r < 8; r++) read_row(r, pat(r, 8'h02), "rd_l2");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
